// File: rtl/vga_frame_scanner_if.sv
// rtl/vga_frame_scanner_if.sv - SRAM read port and VGA output bundle for the frame scanner
interface vga_frame_scanner_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] base_address;
    logic              sram_rd;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_rdata;
    logic [2:0]        vga_r;
    logic [2:0]        vga_g;
    logic [2:0]        vga_b;
    logic              vga_hs;
    logic              vga_vs;
    logic              vga_de;
    logic              paint_done;
    logic              underrun;

    modport master (
        input  base_address, sram_rdata,
        output sram_rd, sram_addr, vga_r, vga_g, vga_b,
               vga_hs, vga_vs, vga_de, paint_done, underrun
    );

    modport slave (
        output base_address, sram_rdata,
        input  sram_rd, sram_addr, vga_r, vga_g, vga_b,
               vga_hs, vga_vs, vga_de, paint_done, underrun
    );
endinterface

// File: rtl/vga_frame_scanner.sv
// rtl/vga_frame_scanner.sv - scans the front video buffer from SRAM out to VGA with a prefetch FIFO
module vga_frame_scanner #(
    parameter int H_ACTIVE     = 800,
    parameter int H_FP         = 56,
    parameter int H_SYNC       = 120,
    parameter int H_BP         = 64,
    parameter int V_ACTIVE     = 600,
    parameter int V_FP         = 37,
    parameter int V_SYNC       = 6,
    parameter int V_BP         = 23,
    parameter int FIFO_DEPTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 20
) (
    input logic                  clk,
    input logic                  rst,
    vga_frame_scanner_if.master  bus
);

    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW          = $clog2(H_TOTAL);
    localparam int VW          = $clog2(V_TOTAL);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;
    localparam int RW          = $clog2(FRAME_WORDS + 1);

    localparam logic [HW-1:0]    H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]    H_ACT_C   = HW'(H_ACTIVE);
    localparam logic [HW-1:0]    HS_ON     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]    HS_OFF    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]    V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]    V_ACT_C   = VW'(V_ACTIVE);
    localparam logic [VW-1:0]    VS_ON     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]    VS_OFF    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [RW-1:0]    LAST_WORD = RW'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        FETCH,
        DONE
    } fetch_state_t;

    logic [HW-1:0]           h_q, h_d;
    logic [VW-1:0]           v_q, v_d;

    logic [8:0]              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    fetch_state_t            state_q, state_d;
    logic [ADDR_W-1:0]       ptr_q, ptr_d;
    logic [RW-1:0]           issued_q, issued_d;
    logic [CNT_W-1:0]        inflight_q, inflight_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic                    sram_rd_q, sram_rd_d;
    logic [ADDR_W-1:0]       sram_addr_q, sram_addr_d;

    logic                    de_q, hs_q, vs_q, paint_q, underrun_q;
    logic [8:0]              rgb_q;

    logic                    de_w, hs_w, vs_w, paint_w, load_w;
    logic                    push_w, pop_w;
    logic [CNT_W:0]          occupancy_w;
    logic [22:0]             unused_rdata;

    assign unused_rdata = bus.sram_rdata[31:9];

    assign de_w    = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign hs_w    = (h_q >= HS_ON) && (h_q < HS_OFF);
    assign vs_w    = (v_q >= VS_ON) && (v_q < VS_OFF);
    assign paint_w = (h_q == '0) && (v_q == V_ACT_C);
    assign load_w  = (h_q == '0) && (v_q == V_LAST);

    // Data returning for a read issued before a frame load belongs to the old frame and is dropped.
    assign push_w      = pipe_q[READ_LATENCY-1] && !load_w;
    assign pop_w       = de_w && (count_q != '0);
    assign occupancy_w = {1'b0, count_q} + {1'b0, inflight_q};

    // Raster position: h wraps each line, v advances on h wrap.
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    // Raster counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // FIFO pointer and occupancy update; a frame load empties the FIFO.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_w) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (load_w) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage keeps only the 9 colour bits of each word.
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= bus.sram_rdata[8:0];
        end
    end

    // Fetch sequencing: issue reads while FIFO plus in-flight reads leave room, one frame's worth per load.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        issued_d    = issued_q;
        sram_rd_d   = 1'b0;
        sram_addr_d = sram_addr_q;
        case (state_q)
            WAIT_FRAME: begin
                state_d = WAIT_FRAME;
            end
            FETCH: begin
                if (occupancy_w < {1'b0, DEPTH_C}) begin
                    sram_rd_d   = 1'b1;
                    sram_addr_d = ptr_q;
                    ptr_d       = ptr_q + 1'b1;
                    issued_d    = issued_q + 1'b1;
                    if (issued_q == LAST_WORD) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (paint_w) begin
                    state_d = WAIT_FRAME;
                end
            end
            default: state_d = WAIT_FRAME;
        endcase
        if (load_w) begin
            state_d   = FETCH;
            ptr_d     = bus.base_address;
            issued_d  = '0;
            sram_rd_d = 1'b0;
        end
    end

    // In-flight tracking: a read counts from its strobe until its data is pushed.
    always_comb begin
        inflight_d = inflight_q;
        case ({sram_rd_d, push_w})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
        pipe_d = '0;
        if (!load_w) begin
            pipe_d[0] = sram_rd_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
        if (load_w) begin
            inflight_d = '0;
        end
    end

    // Fetch state and SRAM read port registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= WAIT_FRAME;
            ptr_q       <= '0;
            issued_q    <= '0;
            inflight_q  <= '0;
            pipe_q      <= '0;
            sram_rd_q   <= 1'b0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            issued_q    <= issued_d;
            inflight_q  <= inflight_d;
            pipe_q      <= pipe_d;
            sram_rd_q   <= sram_rd_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    // Video outputs lag the raster counters by one clock; a starved pixel is black and latches underrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            de_q       <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            paint_q    <= 1'b0;
            underrun_q <= 1'b0;
            rgb_q      <= '0;
        end else begin
            de_q       <= de_w;
            hs_q       <= hs_w;
            vs_q       <= vs_w;
            paint_q    <= paint_w;
            underrun_q <= underrun_q | (de_w && (count_q == '0));
            rgb_q      <= pop_w ? mem_q[rd_ptr_q] : 9'd0;
        end
    end

    assert property (@(posedge clk) disable iff (!rst) !(push_w && (count_q == DEPTH_C)));

    assign bus.sram_rd    = sram_rd_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.vga_r      = rgb_q[8:6];
    assign bus.vga_g      = rgb_q[5:3];
    assign bus.vga_b      = rgb_q[2:0];
    assign bus.vga_hs     = hs_q;
    assign bus.vga_vs     = vs_q;
    assign bus.vga_de     = de_q;
    assign bus.paint_done = paint_q;
    assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb/tb_vga_frame_scanner.sv - scoreboard and table-driven bench for vga_frame_scanner on a reduced raster
module tb_vga_frame_scanner;

    localparam int HA    = 16;
    localparam int HFP   = 4;
    localparam int HS    = 6;
    localparam int HBP   = 6;
    localparam int VA    = 6;
    localparam int VFP   = 2;
    localparam int VS    = 2;
    localparam int VBP   = 2;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int AW    = 20;
    localparam int WORDS = HA * VA;

    logic clk = 1'b0;
    logic rst = 1'b0;

    vga_frame_scanner_if #(.ADDR_W(AW)) vif();

    vga_frame_scanner #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .FIFO_DEPTH(16), .READ_LATENCY(1), .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif)
    );

    always #5 clk = ~clk;

    // SRAM model: data word equals its address, one cycle after the strobe; garbage otherwise.
    always @(posedge clk) begin
        if (vif.sram_rd) vif.sram_rdata <= {12'h000, vif.sram_addr};
        else             vif.sram_rdata <= 32'hFFFF_FE55;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] dut_vid();
        return {vif.vga_de, vif.vga_hs, vif.vga_vs, vif.paint_done, vif.underrun,
                vif.vga_r, vif.vga_g, vif.vga_b};
    endfunction

    typedef struct {
        logic [13:0] vid;
        int          h;
        int          v;
    } exp_t;

    exp_t exp_q[$];

    int          mh = 0;
    int          mv = 0;
    logic        loaded = 1'b0;
    logic        ur_m = 1'b0;
    logic [AW-1:0] lbase = '0;
    int          rd_cnt = 0;
    logic [8:0]  first_seen;
    logic [8:0]  last_seen;

    // Reference raster model: expectation pushed per cycle, compared when the DUT output appears next cycle.
    always @(negedge clk) begin : scoreboard
        exp_t          e;
        logic          de_m, hs_m, vs_m, pd_m;
        logic [AW-1:0] a;
        logic [8:0]    rgb_m;
        if (!rst) begin
            exp_q.delete();
            mh = 0; mv = 0; loaded = 1'b0; ur_m = 1'b0; rd_cnt = 0;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("video h=%0d v=%0d", e.h, e.v), 32'(dut_vid()), 32'(e.vid));
                if (e.h == 0 && e.v == 0) first_seen = {vif.vga_r, vif.vga_g, vif.vga_b};
                if (e.h == HA-1 && e.v == VA-1) last_seen = {vif.vga_r, vif.vga_g, vif.vga_b};
            end
            if (mh == 0 && mv == VT-1) begin
                check("rd_per_frame", 32'(rd_cnt), 32'(loaded ? WORDS : 0));
                rd_cnt = 0;
                lbase  = vif.base_address;
                loaded = 1'b1;
            end
            if (vif.sram_rd) rd_cnt++;
            de_m = (mh < HA) && (mv < VA);
            hs_m = (mh >= HA+HFP) && (mh < HA+HFP+HS);
            vs_m = (mv >= VA+VFP) && (mv < VA+VFP+VS);
            pd_m = (mh == 0) && (mv == VA);
            a    = lbase + AW'(mv*HA + mh);
            rgb_m = (de_m && loaded) ? a[8:0] : 9'd0;
            ur_m = ur_m | (de_m && !loaded);
            e.vid = {de_m, hs_m, vs_m, pd_m, ur_m, rgb_m};
            e.h = mh;
            e.v = mv;
            exp_q.push_back(e);
            mh = mh + 1;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT-1) ? 0 : mv + 1;
            end
        end
    end

    task automatic wait_point(input int th, input int tv);
        int n = 0;
        while (!(mh == th && mv == tv) && n < 2*HT*VT) begin
            @(negedge clk); #1;
            n++;
        end
        check($sformatf("reach h=%0d v=%0d", th, tv), 32'(mh == th && mv == tv), 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " de"},    32'(vif.vga_de), 32'd0);
        check({tag, " hs"},    32'(vif.vga_hs), 32'd0);
        check({tag, " vs"},    32'(vif.vga_vs), 32'd0);
        check({tag, " rgb"},   32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'd0);
        check({tag, " paint"}, 32'(vif.paint_done), 32'd0);
        check({tag, " under"}, 32'(vif.underrun), 32'd0);
        check({tag, " rd"},    32'(vif.sram_rd), 32'd0);
        check({tag, " addr"},  32'(vif.sram_addr), 32'd0);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [8:0]    first_rgb;
        logic [8:0]    last_rgb;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{20'h12340, 9'h140, 9'h19F};
        tbl[1] = '{20'h00000, 9'h000, 9'h05F};
        tbl[2] = '{20'd96,    9'h060, 9'h0BF};
        tbl[3] = '{20'hFFFF0, 9'h1F0, 9'h04F};

        vif.base_address = '0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");

        @(posedge clk); #2;
        rst = 1'b1;

        wait_point(0, VA+1);
        check("underrun after starved frame", 32'(vif.underrun), 32'd1);

        for (int i = 0; i < 4; i++) begin
            wait_point(0, 2);
            vif.base_address = tbl[i].base;
            wait_point(0, VT-1);
            first_seen = 'x;
            last_seen  = 'x;
            wait_point(0, VA+1);
            check($sformatf("vec%0d first pixel", i), 32'(first_seen), 32'(tbl[i].first_rgb));
            check($sformatf("vec%0d last pixel", i),  32'(last_seen),  32'(tbl[i].last_rgb));
        end
        check("underrun sticky", 32'(vif.underrun), 32'd1);

        wait_point(5, 3);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_quiet("async reset");
        vif.base_address = 20'h00300;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("underrun after release", 32'(vif.underrun), 32'd0);
        wait_point(0, VT-1);
        first_seen = 'x;
        last_seen  = 'x;
        wait_point(0, VA+1);
        check("post-reset first pixel", 32'(first_seen), 32'h100);
        check("post-reset last pixel",  32'(last_seen),  32'h15F);
        check("post-reset underrun",    32'(vif.underrun), 32'd1);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_frame_scanner.md
Name: vga_frame_scanner

Overview:
- Display back end that scans the front video buffer out to the VGA connector.
- Reads the pixel words written by the text renderer from SRAM, starting at the renderer-selected base address.
- Generates 800x600@72 timing at the 50 MHz system clock.
- Pulses paint_done once per frame so the renderer can swap buffers and repaint.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (clocks)
- H_SYNC, 120, hsync width
- H_BP, 64, horizontal back porch
- V_ACTIVE, 600, visible lines
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vsync width
- V_BP, 23, vertical back porch
- FIFO_DEPTH, 16, pixel prefetch FIFO entries (power of 2)
- READ_LATENCY, 1, clocks from sram_rd to valid sram_rdata
- ADDR_W, 20, SRAM word address width

Ports:
- clk  in  1  system/pixel clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- base_address  in  ADDR_W  first word of front buffer; sampled only at frame-load point
- sram_rd  out  1  read strobe, one word per cycle
- sram_addr  out  ADDR_W  read address
- sram_rdata  in  32  read data; bits [8:0] = {R[2:0],G[2:0],B[2:0]}, others ignored
- vga_r, vga_g, vga_b  out  3 each  colour, 0 outside active region
- vga_hs, vga_vs  out  1 each  sync, active-high
- vga_de  out  1  active-video flag
- paint_done  out  1  one-cycle pulse per frame
- underrun  out  1  sticky: FIFO empty when a pixel was required

Behaviour:
- Reset (async, rst=0):
  - h=v=0; FIFO empty; fetch state WAIT_FRAME.
  - All outputs 0; sram_addr 0; underrun 0.
- Counters:
  - h counts 0..H_TOTAL-1 (H_TOTAL=1040); v increments on h wrap, 0..V_TOTAL-1 (V_TOTAL=666), then wraps to 0.
- Video outputs, registered one cycle after the counter values:
  - de = h<H_ACTIVE && v<V_ACTIVE.
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs defined the same way on v.
- Pixel pop:
  - Each cycle with de true pops one FIFO word; its colour is driven the next cycle.
  - If the FIFO is empty: drive 0,0,0, set underrun (cleared only by reset), and do not advance the pop stream.
- paint_done: high for exactly one cycle when (h,v) = (0,V_ACTIVE), i.e. first blanking line start.
- Frame load at (h,v) = (0,V_TOTAL-1):
  - Latch base_address into the read pointer.
  - Flush FIFO and in-flight reads; discard returning data tagged to the old frame.
  - Enter FETCH.
- Fetch FSM states: WAIT_FRAME, FETCH, DONE.
  - FETCH:
    - Issue sram_rd with sram_addr = pointer while (FIFO count + in-flight) < FIFO_DEPTH.
    - Pointer increments per issue.
    - Exactly H_ACTIVE*V_ACTIVE = 480000 reads per frame, then go to DONE.
  - Returning data is pushed READ_LATENCY cycles after its sram_rd.
  - DONE -> WAIT_FRAME at paint_done; WAIT_FRAME -> FETCH at frame load.
  - A frame load in any state restarts the fetch.
- Pointer arithmetic: modulo 2^ADDR_W; wraps silently.
- Prefetch timing: the FIFO reaches full within FIFO_DEPTH+READ_LATENCY cycles of load, far before the first active pixel.
- Simultaneous events:
  - Push and pop in the same cycle leave the count unchanged.
  - A push when full cannot occur; assert in simulation.
- base_address changes between load points have no effect on the current frame.

Test Plan:
- Reset then release; SRAM model returns data = address; base_address = 0x12340 -> after load at v=665, first pixel at (h,v) = (0,0) has colour bits = 0x12340[8:0]; consecutive pixels increment; pixel (799,599) = base+479999.
- Sync check over one full frame:
  - hs high for 120 clocks starting at h=856.
  - vs high for 6 lines starting at v=637.
  - de high for exactly 480000 cycles.
  - paint_done exactly one pulse, at (0,600).
- Change base_address from 0 to 480000 mid-frame -> current frame continues from 0; next frame starts at 480000.
- SRAM stall model (data delayed so FIFO drains during line 10) -> black pixels at starved positions; underrun=1 and stays 1 through later frames; remaining pixels keep address order.
- Assert rst=0 mid-line while reads in flight -> all outputs 0 immediately; after release, first full frame displays correct data with no stale words.
- Count sram_rd pulses per frame = 480000; FIFO count never exceeds 16; no rd issued in WAIT_FRAME or DONE.
